cmp_seq_ctrl: RTL and testbench
===============================

Name: cmp_seq_ctrl

Overview:
- Sequencing controller that performs an N-bit magnitude compare using one shared 1-bit cascade slice.
- Bits are walked MSB-first, one per clock, carrying the equal/lower/greater cascade state in registers between steps.
- Operands arrive and results leave over valid/ready handshakes.
- It is the area-optimised, multi-cycle alternative to the unrolled combinational comparator chain, and is used where compare throughput is not critical.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- EARLY_EXIT, 1, 1 = finish at the first differing bit; 0 = always scan all WIDTH bits (fixed latency).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- equal  output  1  a == b.
- lower  output  1  a < b.
- greater  output  1  a > b.
- cycles  output  $clog2(WIDTH+1)  number of slice steps used for this result.
- busy  output  1  state != IDLE.

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-SCAN or in DONE): go to IDLE immediately and abort any operation in flight.
  - Outputs under reset: in_ready=1, out_valid=0, equal=0, lower=0, greater=0, cycles=0, busy=0.
  - On reset release, the first accept happens no earlier than the first rising edge with rst_n high.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - register a and b;
    - set cascade eq_r=1, lt_r=0, gt_r=0;
    - set idx=WIDTH-1, step=0;
    - go to SCAN.
  - SCAN: in_ready=0. Each cycle the slice evaluates bit idx from eq_r/lt_r/gt_r. Registered next-state:
    - lt_n = lt_r | (eq_r & ~a[idx] & b[idx])
    - gt_n = gt_r | (eq_r & a[idx] & ~b[idx])
    - eq_n = eq_r & ~(a[idx] ^ b[idx])
    - step increments by 1.
    - Exit condition: idx==0, or (EARLY_EXIT && !eq_n). On exit, load equal/lower/greater from eq_n/lt_n/gt_n, load cycles=step+1, go to DONE. Otherwise idx decrements.
  - DONE: out_valid=1. Result outputs are held stable while out_valid is high and out_ready is low.
    - On out_ready, go to IDLE. The result registers keep their value until the next result is loaded.
- Latency, counted from the accept edge to out_valid high:
  - EARLY_EXIT=0: always WIDTH cycles.
  - EARLY_EXIT=1: (WIDTH - k) cycles, where k is the index of the most significant differing bit; WIDTH cycles if a==b.
- Throughput: no overlap. in_ready is 0 in SCAN and in DONE. The minimum spacing between accepts is latency+2 cycles.
  - An out_ready/in_valid pair arriving in the same cycle in DONE completes the output only; the input is accepted in the following IDLE cycle.
- Invariant: exactly one of equal/lower/greater is 1 whenever out_valid=1.
- Operand inputs a and b are ignored outside the IDLE accept cycle, so changes during SCAN have no effect.
- out_ready while out_valid=0 is ignored. in_valid may drop without an accept; nothing is latched.

Decomposition:
- Package cmp_pkg:
  - state enum (IDLE, SCAN, DONE);
  - cmp_res_t struct {eq, lt, gt};
  - constant CMP_RES_INIT = '{1,0,0}.
- Sub-module cmp_slice: a purely combinational 1-bit cascade cell. Inputs are the a/b bits and cmp_res_t in; output is cmp_res_t out. It is instantiated once inside cmp_seq_ctrl.
- The FSM, operand registers, index counter and step counter live in cmp_seq_ctrl.

Test Plan (WIDTH=8):
1. EARLY_EXIT=1, a=0xA5, b=0xA5, out_ready=1 -> out_valid 8 cycles after accept; equal=1, lower=0, greater=0, cycles=8.
2. EARLY_EXIT=1, a=0x80, b=0x7F -> out_valid 1 cycle after accept; greater=1, cycles=1. The same operands with EARLY_EXIT=0 -> greater=1, cycles=8.
3. a=0x12, b=0x13 -> lower=1, cycles=8. Then a=0x13, b=0x12 -> greater=1, cycles=8.
4. a=0x40, b=0x00, out_ready held low 5 cycles -> out_valid, greater and cycles=2 stay stable for all 5 cycles; in_ready=0 throughout; IDLE one cycle after out_ready=1.
5. Accept a=0xFF, b=0x00 with EARLY_EXIT=0; assert rst_n=0 at SCAN step 3 -> outputs immediately return to reset values. After release, a=0x01, b=0x01 -> equal=1, cycles=8.
6. Back-to-back: in_valid held high with 20 random pairs and random out_ready -> each result matches the golden (a<b, a==b, a>b) model; one-hot flags; no pair is dropped or duplicated.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// eq/lt/gt cascade record passed between bit steps.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_res_t;

  // Cascade seed: nothing examined yet, so the operands are "equal so far".
  localparam cmp_res_t CMP_RES_INIT = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};

endpackage

// File: rtl/cmp_slice.sv
// One-bit magnitude compare cascade cell. Once a difference has been seen the
// lt/gt flags latch and eq stays low for all lower bits.
module cmp_slice
  import cmp_pkg::*;
(
  input  logic     i_a,
  input  logic     i_b,
  input  cmp_res_t i_res,
  output cmp_res_t o_res
);

  assign o_res.lt = i_res.lt | (i_res.eq & ~i_a & i_b);
  assign o_res.gt = i_res.gt | (i_res.eq & i_a & ~i_b);
  assign o_res.eq = i_res.eq & ~(i_a ^ i_b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first through a
// single shared cmp_slice, one bit per clock, with the cascade held in flops.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       equal,
  output logic                       lower,
  output logic                       greater,
  output logic [$clog2(WIDTH+1)-1:0] cycles,
  output logic                       busy,
  output logic [1:0]                 o_dbg_state
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH-1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  cmp_res_t         r_casc;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_step;
  cmp_res_t         r_res;
  logic [CNT_W-1:0] r_cycles;

  cmp_res_t w_next;
  logic     w_last;

  cmp_slice u_slice (
    .i_a   (r_a[r_idx]),
    .i_b   (r_b[r_idx]),
    .i_res (r_casc),
    .o_res (w_next)
  );

  assign w_last = (r_idx == '0) || (EARLY_EXIT && !w_next.eq);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the
  // result stays frozen until out_ready is seen there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_casc   <= CMP_RES_INIT;
      r_idx    <= '0;
      r_step   <= '0;
      r_res    <= '0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_casc  <= CMP_RES_INIT;
            r_idx   <= IDX_MSB;
            r_step  <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_casc <= w_next;
          r_step <= r_step + 1'b1;
          if (w_last) begin
            r_res    <= w_next;
            r_cycles <= r_step + 1'b1;
            r_state  <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign equal       = r_res.eq;
  assign lower       = r_res.lt;
  assign greater     = r_res.gt;
  assign cycles      = r_cycles;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: one fixed-latency and one early-exit instance, a
// cycle-level reference model, directed vectors and a pair scoreboard.
module tb_cmp_seq_ctrl;

  localparam int W  = 8;
  localparam int RW = 7;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]        in_valid_s;
  logic [1:0]        in_ready_s;
  logic [1:0]        out_valid_s;
  logic [1:0]        out_ready_s;
  logic [1:0]        equal_s;
  logic [1:0]        lower_s;
  logic [1:0]        greater_s;
  logic [1:0]        busy_s;
  logic [1:0][W-1:0] a_s;
  logic [1:0][W-1:0] b_s;
  logic [1:0][3:0]   cycles_s;
  logic [1:0][1:0]   dbg_s;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] sb_e;
  bit            sb_on    = 1'b0;
  bit            drv_done = 1'b0;
  logic [W-1:0]  av, bv;

  bit            m_busy[2];
  int            m_wait[2];
  logic [RW-1:0] m_res[2];

  always #5 clk = ~clk;

  cmp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .equal(equal_s[0]), .lower(lower_s[0]), .greater(greater_s[0]),
    .cycles(cycles_s[0]), .busy(busy_s[0]), .o_dbg_state(dbg_s[0])
  );

  cmp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .equal(equal_s[1]), .lower(lower_s[1]), .greater(greater_s[1]),
    .cycles(cycles_s[1]), .busy(busy_s[1]), .o_dbg_state(dbg_s[1])
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected {eq, lt, gt, cycles}; cycles also equals accept-to-valid latency.
  function automatic logic [RW-1:0] exp_result(input bit ee, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    int k;
    int n;
    d = x ^ y;
    k = -1;
    for (int i = 0; i < W; i++) if (d[i]) k = i;
    n = (!ee || k < 0) ? W : W - k;
    return {x == y, x < y, x > y, n[3:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        m_busy[s] <= 1'b0;
        m_wait[s] <= 0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (m_busy[s]) begin
          if (m_wait[s] > 0) m_wait[s] <= m_wait[s] - 1;
          else if (out_ready_s[s]) m_busy[s] <= 1'b0;
        end else if (in_valid_s[s]) begin
          m_res[s]  <= exp_result(s == 1, a_s[s], b_s[s]);
          m_wait[s] <= int'(exp_result(s == 1, a_s[s], b_s[s]) & 7'h0F);
          m_busy[s] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("in_ready%0d", s), in_ready_s[s], m_busy[s] ? 0 : 1);
        chk($sformatf("busy%0d", s), busy_s[s], m_busy[s] ? 1 : 0);
        chk($sformatf("out_valid%0d", s), out_valid_s[s], (m_busy[s] && m_wait[s] == 0) ? 1 : 0);
        if (m_busy[s] && m_wait[s] == 0) begin
          chk($sformatf("result%0d", s), {equal_s[s], lower_s[s], greater_s[s], cycles_s[s]}, m_res[s]);
          chk($sformatf("onehot%0d", s), int'(equal_s[s]) + int'(lower_s[s]) + int'(greater_s[s]), 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && sb_on && out_valid_s[1] && out_ready_s[1]) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_pair", {equal_s[1], lower_s[1], greater_s[1], cycles_s[1]}, sb_e);
      end
    end
  end

  task automatic start_op(input int s, input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    int g;
    g = 0;
    a_s[s] = x;
    b_s[s] = y;
    in_valid_s[s] = 1'b1;
    while (!in_ready_s[s] && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) in_valid_s[s] = 1'b0;
  endtask

  task automatic wait_result(input int s, output int lat);
    lat = 0;
    while (!out_valid_s[s] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) chk("valid_timeout", 0, 1);
  endtask

  task automatic finish_op(input int s);
    out_ready_s[s] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[s] = 1'b0;
  endtask

  task automatic directed(input string nm, input int s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int elat, input logic [RW-1:0] e);
    int lat;
    start_op(s, x, y, 1'b0);
    wait_result(s, lat);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_res"}, {equal_s[s], lower_s[s], greater_s[s], cycles_s[s]}, e);
    finish_op(s);
  endtask

  task automatic check_reset_outputs(input string nm, input int s);
    chk({nm, "_in_ready"}, in_ready_s[s], 1);
    chk({nm, "_out_valid"}, out_valid_s[s], 0);
    chk({nm, "_flags"}, {equal_s[s], lower_s[s], greater_s[s]}, 0);
    chk({nm, "_cycles"}, cycles_s[s], 0);
    chk({nm, "_busy"}, busy_s[s], 0);
  endtask

  initial begin
    int lat;
    rst_n       = 1'b0;
    in_valid_s  = '0;
    out_ready_s = '0;
    a_s         = '0;
    b_s         = '0;
    #22;
    check_reset_outputs("rst_fix", 0);
    check_reset_outputs("rst_ee", 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal operands scan every bit even with early exit.
    out_ready_s[1] = 1'b1;
    start_op(1, 8'hA5, 8'hA5, 1'b0);
    wait_result(1, lat);
    chk("t1_lat", lat, 8);
    chk("t1_res", {equal_s[1], lower_s[1], greater_s[1], cycles_s[1]}, {1'b1, 1'b0, 1'b0, 4'd8});
    @(posedge clk); #1;
    out_ready_s[1] = 1'b0;
    chk("t1_idle", in_ready_s[1], 1);

    directed("t2_ee",  1, 8'h80, 8'h7F, 1, {1'b0, 1'b0, 1'b1, 4'd1});
    directed("t2_fix", 0, 8'h80, 8'h7F, 8, {1'b0, 1'b0, 1'b1, 4'd8});
    directed("t3_lt",  1, 8'h12, 8'h13, 8, {1'b0, 1'b1, 1'b0, 4'd8});
    directed("t3_gt",  1, 8'h13, 8'h12, 8, {1'b0, 1'b0, 1'b1, 4'd8});
    directed("t3_fix_lt", 0, 8'h00, 8'hFF, 8, {1'b0, 1'b1, 1'b0, 4'd8});

    // Result must hold while the consumer stalls.
    start_op(1, 8'h40, 8'h00, 1'b0);
    wait_result(1, lat);
    chk("t4_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", out_valid_s[1], 1);
      chk("t4_hold_res", {equal_s[1], lower_s[1], greater_s[1], cycles_s[1]}, {1'b0, 1'b0, 1'b1, 4'd2});
      chk("t4_hold_in_ready", in_ready_s[1], 0);
      @(posedge clk); #1;
    end
    finish_op(1);
    chk("t4_idle_in_ready", in_ready_s[1], 1);
    chk("t4_idle_busy", busy_s[1], 0);

    // Asynchronous reset in the middle of a scan.
    start_op(0, 8'hFF, 8'h00, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t5_busy_before", busy_s[0], 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst", 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed("t5_after", 0, 8'h01, 8'h01, 8, {1'b1, 1'b0, 1'b0, 4'd8});

    // Back-to-back stream with random consumer stalls.
    sb_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          av = W'($urandom_range(0, 255));
          bv = (i % 4 == 0) ? av : W'($urandom_range(0, 255));
          exp_q.push_back(exp_result(1'b1, av, bv));
          start_op(1, av, bv, 1'b1);
        end
        in_valid_s[1] = 1'b0;
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          out_ready_s[1] = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready_s[1] = 1'b1;
    lat = 0;
    while (exp_q.size() != 0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    out_ready_s[1] = 1'b0;
    sb_on = 1'b0;
    chk("t6_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
